// File: rtl/ushift_pkg.sv
// rtl/ushift_pkg.sv - opcodes, state encoding and op classification for ushift_seq
package ushift_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_SHR = 3'b001,
    OP_SHL = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR = 3'b100,
    OP_ROL = 3'b101,
    OP_ASR = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/ushift_step.sv
// rtl/ushift_step.sv - combinational single-position shift/rotate step
module ushift_step
  import ushift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q_next,
  output logic             dropped
);

  always_comb begin
    q_next  = q;
    dropped = 1'b0;
    case (op)
      OP_SHR: begin q_next = {sin_r, q[WIDTH-1:1]};    dropped = q[0];       end
      OP_SHL: begin q_next = {q[WIDTH-2:0], sin_l};    dropped = q[WIDTH-1]; end
      OP_ROR: begin q_next = {q[0], q[WIDTH-1:1]};     dropped = q[0];       end
      OP_ROL: begin q_next = {q[WIDTH-2:0], q[WIDTH-1]}; dropped = q[WIDTH-1]; end
      OP_ASR: begin q_next = {q[WIDTH-1], q[WIDTH-1:1]}; dropped = q[0];     end
      default: ;
    endcase
  end

endmodule

// File: rtl/ushift_seq.sv
// rtl/ushift_seq.sv - command-driven multi-mode shift sequencer, one bit position per clock
module ushift_seq
  import ushift_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int AMT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [AMT_BITS-1:0] cmd_amt,
  input  logic [WIDTH-1:0]    d,
  input  logic                sin_r,
  input  logic                sin_l,
  output logic [WIDTH-1:0]    q,
  output logic                sout,
  output logic                sout_valid,
  output logic                busy,
  output logic                done
);

  state_e              state;
  logic [2:0]          op_r;
  logic [AMT_BITS-1:0] cnt;
  logic [WIDTH-1:0]    step_q;
  logic                step_drop;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);

  ushift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .op      (op_r),
    .sin_r   (sin_r),
    .sin_l   (sin_l),
    .q_next  (step_q),
    .dropped (step_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_r       <= OP_NOP;
      cnt        <= '0;
      q          <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      sout_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Zero-distance shifts complete like a NOP without entering RUN.
            if (is_shift(cmd_op) && (cmd_amt != '0)) begin
              op_r  <= cmd_op;
              cnt   <= cmd_amt;
              state <= ST_RUN;
            end else begin
              if (cmd_op == OP_LOAD) q <= d;
              else if (cmd_op == OP_CLR) q <= '0;
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q          <= step_q;
          sout       <= step_drop;
          sout_valid <= 1'b1;
          cnt        <= cnt - AMT_BITS'(1);
          if (cnt == AMT_BITS'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ushift_seq.md
# ushift_seq

Parametrised multi-mode shift sequencer: a command-driven register that loads, clears, or performs logical, arithmetic and rotating shifts of a programmable distance, one bit position per clock. It succeeds the single-step 4-mode universal shift register in the datapath. It adds:

- a valid/ready command handshake;
- multi-cycle shift distances with a busy/done protocol;
- a serial output tap, so it can act as a parallel-to-serial and serial-to-parallel engine.

## Interface

Parameters:
- WIDTH, 16, register width in bits (≥2)
- AMT_BITS, 4, width of shift-distance field; max distance 2^AMT_BITS−1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  operation code (see Operation)
- cmd_amt  in  AMT_BITS  shift distance in bit positions
- d  in  WIDTH  parallel load data
- sin_r  in  1  fill bit entering MSB on logical right shift, sampled every step
- sin_l  in  1  fill bit entering LSB on left shift, sampled every step
- q  out  WIDTH  register contents
- sout  out  1  bit that left the register on the most recent step
- sout_valid  out  1  sout updated on the preceding edge
- busy  out  1  multi-cycle shift in progress (state RUN)
- done  out  1  one-cycle pulse, command completed

## Operation

- Opcodes:
  - 000 NOP
  - 001 SHR: logical right, MSB ← sin_r
  - 010 SHL: left, LSB ← sin_l
  - 011 LOAD: q ← d
  - 100 ROR
  - 101 ROL
  - 110 ASR: MSB replicated
  - 111 CLR: q ← 0
- FSM states IDLE, RUN. Accept = cmd_valid & cmd_ready.
- IDLE, accept of NOP/LOAD/CLR, or of a shift op with cmd_amt=0:
  - q updates (or holds) on the accept edge.
  - Stays IDLE.
  - done high the next cycle.
- IDLE, accept of a shift op with cmd_amt=N≥1:
  - op and N are latched; counter ← N; move to RUN. q is unchanged on the accept edge.
- RUN: each edge performs one step of the latched op and decrements the counter.
  - On the step where the counter reaches 0, return to IDLE; done is high the following cycle.
- Step rules:
  - Right ops drop q[0]. Left ops drop q[WIDTH−1]. The dropped bit goes to sout.
  - ROR fills the MSB with the dropped q[0]. ROL fills the LSB with the dropped q[WIDTH−1].
  - ASR fills the MSB with q[WIDTH−1].
- sout_valid goes high for the cycle after each step edge, otherwise low. sout holds its last value.
- In RUN, cmd_valid, cmd_op, cmd_amt and d are ignored. sin_r and sin_l are live.
- Reset, asserted at any time including mid-RUN:
  - q=0, sout=0, sout_valid=0, done=0, busy=0.
  - State IDLE; cmd_ready=1 once rst deasserts.

## Timing

- cmd_ready = (state==IDLE), decoded combinationally from the state register.
- busy = (state==RUN).
- Single-cycle ops: q valid the cycle after accept, coincident with done.
- Shift of N≥1:
  - busy high for N cycles, starting the cycle after accept.
  - q reaches its final value at the N-th edge after the accept edge.
  - done and cmd_ready are high in the cycle after that edge.
- Back-to-back: a new command may be accepted in the done cycle. Throughput is 1 command per cycle for single-cycle ops, and 1 per N+1 cycles for shifts of N≥1.
- Distances ≥ WIDTH are legal: logical shifts then produce all-fill; rotates wrap modulo WIDTH.

## Structure

- Package ushift_pkg holds:
  - the opcode constants OP_NOP…OP_CLR;
  - the state encoding (ST_IDLE, ST_RUN);
  - a helper classifying ops as shift or single-cycle.
- Sub-module ushift_step: purely combinational one-position step. Inputs q, op, sin_r, sin_l; outputs next q and dropped bit. The sequencer instantiates it once.
- Parent holds the FSM, distance counter, latched op, output registers and handshake.

## Test plan

All scenarios use WIDTH=8, AMT_BITS=4.

- Reset: start SHR amt=5, assert rst after 2 steps → q=0x00, busy=0, done=0, sout_valid=0; cmd_ready=1 after release.
- LOAD d=0xA5 → q=0xA5 one edge after accept; done one cycle; busy never set.
- From q=0xA5, SHR amt=3 with sin_r=1:
  - q steps 0xD2, 0xE9, 0xF4;
  - sout 1,0,1 with sout_valid high for 3 cycles;
  - busy for 3 cycles, then done.
- From q=0x81, ROL amt=8:
  - q returns to 0x81 after 8 steps;
  - sout sequence 1,0,0,0,0,0,0,1.
- From q=0x90, ASR amt=2 → q=0xC8 then 0xE4. Then SHL amt=0 → q stays 0xE4, done the next cycle.
- Handshake:
  - cmd_valid held high with CLR during RUN of SHL amt=4 → ignored until the done cycle, then accepted.
  - q=0x00 one edge later; done pulses again.
